// File: rtl/leb128_encoder_pkg.sv
// Shared LEB128 constants, FSM state type and operand normalisation.
// The decoder side uses the same byte limits and bit positions.
package leb128_encoder_pkg;

  localparam int unsigned LEB128_MAX_I32   = 5;
  localparam int unsigned LEB128_MAX_I64   = 10;
  localparam int unsigned LEB128_CONT_BIT  = 7;
  localparam int unsigned LEB128_PAYLOAD_W = 7;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_e;

  // 32-bit operands are widened so the byte rule can always work on 64 bits.
  function automatic logic [63:0] normalise(input logic [63:0] v,
                                            input logic        sgn,
                                            input logic        is64);
    logic [63:0] r;
    if (is64)     r = v;
    else if (sgn) r = {{32{v[31]}}, v[31:0]};
    else          r = {32'h0, v[31:0]};
    return r;
  endfunction

endpackage

// File: rtl/leb128_encoder_if.sv
// Producer/sink handshake bundle for the LEB128 encoder.
// slave = encoder side, master = producer + byte sink side.
interface leb128_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic        in_signed;
  logic        in_is64;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        done;
  logic [3:0]  out_len;

  modport slave (
    input  in_valid, in_value, in_signed, in_is64, out_ready,
    output in_ready, out_valid, out_byte, out_last, done, out_len
  );

  modport master (
    output in_valid, in_value, in_signed, in_is64, out_ready,
    input  in_ready, out_valid, out_byte, out_last, done, out_len
  );
endinterface

// File: rtl/leb128_encoder_byte.sv
// Combinational LEB128 byte former: payload, termination rule and remainder.
module leb128_byte
  import leb128_encoder_pkg::*;
(
  input  logic [63:0] r,
  input  logic        sgn,
  output logic [7:0]  enc_byte,
  output logic        last,
  output logic [63:0] rest
);

  always_comb begin
    rest = sgn ? 64'($signed(r) >>> LEB128_PAYLOAD_W) : (r >> LEB128_PAYLOAD_W);
    // Signed streams stop once the remaining bits are pure sign copies of bit 6.
    if (sgn)
      last = ((rest == '0) && !r[LEB128_PAYLOAD_W-1]) ||
             ((rest == '1) &&  r[LEB128_PAYLOAD_W-1]);
    else
      last = (rest == '0);
    enc_byte = {~last, r[LEB128_PAYLOAD_W-1:0]};
  end

endmodule

// File: rtl/leb128_encoder.sv
// Serial LEB128 encoder: accepts one 32/64-bit operand, emits its minimal
// signed or unsigned byte sequence one byte per valid/ready handshake.
module leb128_encoder
  import leb128_encoder_pkg::*;
#(
  parameter int unsigned MAX_BYTES = LEB128_MAX_I64
) (
  input  logic             clk,
  input  logic             reset,
  leb128_encoder_if.slave  bus
);

  state_e      state_q, state_d;
  logic [63:0] r_q, r_d;
  logic        sgn_q, sgn_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [3:0]  len_q, len_d;

  logic [7:0]  bf_byte;
  logic        bf_last;
  logic [63:0] bf_rest;
  logic        last_eff;
  logic        accept_in;
  logic        accept_out;

  leb128_byte u_byte (
    .r        (r_q),
    .sgn      (sgn_q),
    .enc_byte (bf_byte),
    .last     (bf_last),
    .rest     (bf_rest)
  );

  // The count cap is redundant for legal operands but bounds the counter.
  assign last_eff   = bf_last || (cnt_q == 4'(MAX_BYTES - 1));
  assign accept_in  = (state_q == ST_IDLE) && bus.in_valid;
  assign accept_out = (state_q == ST_EMIT) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_in) begin
          state_d = ST_EMIT;
          r_d     = normalise(bus.in_value, bus.in_signed, bus.in_is64);
          sgn_d   = bus.in_signed;
          cnt_d   = '0;
        end
      end
      ST_EMIT: begin
        if (accept_out) begin
          if (last_eff) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            len_d   = cnt_q + 4'd1;
          end else begin
            r_d   = bf_rest;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      len_q   <= len_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.out_byte  = (state_q == ST_EMIT) ? {~last_eff, bf_byte[6:0]} : '0;
  assign bus.out_last  = (state_q == ST_EMIT) && last_eff;
  assign bus.done      = done_q;
  assign bus.out_len   = len_q;

endmodule

// File: tb/tb_leb128_encoder.sv
// Directed bench for leb128_encoder with hand-computed LEB128 byte streams.
module tb_leb128_encoder;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  leb128_encoder_if bus ();

  leb128_encoder #(.MAX_BYTES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one operand at the current negedge and consume n bytes (first byte in
  // exp[7:0]). Returns at the negedge where done should be high.
  task automatic run(input string tag, input logic [63:0] v, input logic s,
                     input logic w, input logic [79:0] exp, input int n,
                     input int stall, input bit toggle);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_value  = v;
    bus.in_signed = s;
    bus.in_is64   = w;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_value  = ~v;
    bus.in_signed = ~s;
    bus.in_is64   = ~w;
    for (int i = 0; i < n; i++) begin
      if (toggle) begin
        bus.in_valid  = ~bus.in_valid;
        bus.in_value  = {$urandom, $urandom};
        bus.in_signed = ~bus.in_signed;
        if (i == n - 1) begin
          bus.in_valid  = 1'b1;
          bus.in_value  = 64'd5;
          bus.in_signed = 1'b0;
          bus.in_is64   = 1'b1;
        end
      end
      chk($sformatf("%s.valid%0d", tag, i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("%s.busy%0d", tag, i), 64'(bus.in_ready), 64'd0);
      chk($sformatf("%s.byte%0d", tag, i), 64'(bus.out_byte), 64'(exp[8*i +: 8]));
      chk($sformatf("%s.last%0d", tag, i), 64'(bus.out_last), 64'(i == n - 1));
      chk($sformatf("%s.nodone%0d", tag, i), 64'(bus.done), 64'd0);
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        for (int j = 0; j < stall; j++) begin
          @(negedge clk);
          chk($sformatf("%s.stall_valid%0d", tag, i), 64'(bus.out_valid), 64'd1);
          chk($sformatf("%s.stall_byte%0d", tag, i), 64'(bus.out_byte), 64'(exp[8*i +: 8]));
          chk($sformatf("%s.stall_last%0d", tag, i), 64'(bus.out_last), 64'(i == n - 1));
          chk($sformatf("%s.stall_busy%0d", tag, i), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".len"}, 64'(bus.out_len), 64'(n));
    chk({tag, ".idle_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".idle_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  // One idle cycle: done must have dropped, length must be held.
  task automatic after_done(input string tag, input int n);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, ".len_held"}, 64'(bus.out_len), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_signed = 1'b0;
    bus.in_is64   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.out_last", 64'(bus.out_last), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.out_len", 64'(bus.out_len), 64'd0);
    chk("rst.out_byte", 64'(bus.out_byte), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run("u624485", 64'd624485, 1'b0, 1'b1, 80'h26_8EE5, 3, 0, 1'b0);
    after_done("u624485", 3);

    run("s0",       64'd0,                 1'b1, 1'b1, 80'h00,       1, 0, 1'b0); after_done("s0", 1);
    run("s-1",      64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 80'h7F,     1, 0, 1'b0); after_done("s-1", 1);
    run("s63",      64'd63,                1'b1, 1'b1, 80'h3F,       1, 0, 1'b0); after_done("s63", 1);
    run("s64",      64'd64,                1'b1, 1'b1, 80'h00C0,     2, 0, 1'b0); after_done("s64", 2);
    run("s-64",     64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 1'b1, 80'h40,     1, 0, 1'b0); after_done("s-64", 1);
    run("s-65",     64'hFFFF_FFFF_FFFF_FFBF, 1'b1, 1'b1, 80'h7FBF,   2, 0, 1'b0); after_done("s-65", 2);
    run("s-123456", 64'hFFFF_FFFF_FFFE_1DC0, 1'b1, 1'b1, 80'h78BBC0, 3, 0, 1'b0); after_done("s-123456", 3);

    run("s32min", 64'hDEAD_BEEF_8000_0000, 1'b1, 1'b0, 80'h78_8080_8080, 5, 0, 1'b0);
    after_done("s32min", 5);
    run("u32msb", 64'hDEAD_BEEF_8000_0000, 1'b0, 1'b0, 80'h08_8080_8080, 5, 0, 1'b0);
    after_done("u32msb", 5);
    run("u64max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 80'h01_FFFF_FFFF_FFFF_FFFF_FF, 10, 0, 1'b0);
    after_done("u64max", 10);

    run("bp624485", 64'd624485, 1'b0, 1'b1, 80'h26_8EE5, 3, 3, 1'b0);
    after_done("bp624485", 3);

    // Reset after the first byte of a 10-byte stream is consumed.
    chk("mid.in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_value  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_signed = 1'b0;
    bus.in_is64   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid.byte0", 64'(bus.out_byte), 64'hFF);
    @(negedge clk);
    chk("mid.byte1_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid.out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid.in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("mid.done", 64'(bus.done), 64'd0);
    chk("mid.out_len", 64'(bus.out_len), 64'd0);
    run("post_rst5", 64'd5, 1'b0, 1'b1, 80'h05, 1, 0, 1'b0);
    after_done("post_rst5", 1);

    // Inputs churn while busy; operand 5 is left presented so it is taken at done.
    run("busy", 64'hFFFF_FFFF_FFFE_1DC0, 1'b1, 1'b1, 80'h78BBC0, 3, 1, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy.next_valid", 64'(bus.out_valid), 64'd1);
    chk("busy.next_byte", 64'(bus.out_byte), 64'h05);
    chk("busy.next_last", 64'(bus.out_last), 64'd1);
    chk("busy.next_nodone", 64'(bus.done), 64'd0);
    @(negedge clk);
    chk("busy.next_done", 64'(bus.done), 64'd1);
    chk("busy.next_len", 64'(bus.out_len), 64'd1);
    after_done("busy.next", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
